// File: rtl/syncount_up.sv
// Modulo-MODULUS up counter built from T flip-flop cells with toggle-enable next state.
// Define SYNCOUNT_UP_TC_REG_EN to register tc_o; default is a combinational tc_o.

module syncount_up_tff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic t_i,
  output logic q_o
);

  logic q_q;
  logic q_d;

  assign q_d = q_q ^ t_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

module syncount_up #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] q_o,
  output logic             tc_o,
  output logic             err_o
);

  localparam logic [WIDTH-1:0] TERM  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] t_inc;
  logic [WIDTH-1:0] t_d;
  logic [WIDTH-1:0] load_tgt;
  logic             load_ok;
  logic             at_term;
  logic             wrap;
  logic             err_q;
  logic             err_d;

  assign at_term  = (cnt_q == TERM);
  assign load_ok  = ({1'b0, load_val_i} < MOD_W);
  assign load_tgt = load_ok ? load_val_i : '0;
  assign wrap     = en_i & ~load_i & at_term;

  // Bit k toggles when every lower bit is already set.
  always_comb begin
    logic carry;
    carry = 1'b1;
    t_inc = '0;
    for (int k = 0; k < WIDTH; k++) begin
      t_inc[k] = carry;
      carry    = carry & cnt_q[k];
    end
  end

  always_comb begin
    t_d = '0;
    if (load_i) begin
      t_d = cnt_q ^ load_tgt;
    end else if (wrap) begin
      t_d = cnt_q;
    end else if (en_i) begin
      t_d = t_inc;
    end
  end

  for (genvar k = 0; k < WIDTH; k++) begin : g_bit
    syncount_up_tff u_tff (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .t_i   (t_d[k]),
      .q_o   (cnt_q[k])
    );
  end

  assign err_d = err_q | (load_i & ~load_ok);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

`ifdef SYNCOUNT_UP_TC_REG_EN
  logic tc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tc_q <= 1'b0;
    end else begin
      tc_q <= wrap;
    end
  end

  assign tc_o = tc_q;
`else
  assign tc_o = wrap & ~rst_i;
`endif

  assign q_o   = cnt_q;
  assign err_o = err_q;

endmodule

// File: tb/tb_syncount_up.sv
// Randomized and directed bench for syncount_up, modulo-6 and modulo-8 instances.
// Expected values come from a plain arithmetic model of the counting rules.

module tb_syncount_up;

  logic       clk = 1'b0;
  logic       rst, en, load;
  logic [2:0] val;
  logic [2:0] q6, q8;
  logic       tc6, tc8, err6, err8;

  int checks = 0;
  int errors = 0;

  int m6, m8;
  bit e6, e8, wr6, wr8;
  int tc8_seen;
  int q6_seen;

  always #5 clk = ~clk;

  syncount_up #(.WIDTH(3), .MODULUS(6)) dut6 (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .load_i     (load),
    .load_val_i (val),
    .q_o        (q6),
    .tc_o       (tc6),
    .err_o      (err6)
  );

  syncount_up #(.WIDTH(3), .MODULUS(8)) dut8 (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .load_i     (load),
    .load_val_i (val),
    .q_o        (q8),
    .tc_o       (tc8),
    .err_o      (err8)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step_model(input int m_mod, inout int m, inout bit e,
                            inout bit wr);
    if (rst) begin
      m = 0; e = 0; wr = 0;
    end else if (load) begin
      if (int'(val) < m_mod) m = int'(val);
      else begin m = 0; e = 1; end
      wr = 0;
    end else if (en) begin
      wr = (m == m_mod - 1);
      m  = (m + 1) % m_mod;
    end else begin
      wr = 0;
    end
  endtask

  task automatic cyc(input bit r, input bit l, input int v, input bit e_in);
    rst = r; load = l; val = 3'(v); en = e_in;
    #1;
`ifndef SYNCOUNT_UP_TC_REG_EN
    chk("tc6_comb", int'(tc6), int'((m6 == 5) && en && !load && !rst));
    chk("tc8_comb", int'(tc8), int'((m8 == 7) && en && !load && !rst));
    tc8_seen = int'(tc8);
`endif
    @(posedge clk);
    step_model(6, m6, e6, wr6);
    step_model(8, m8, e8, wr8);
    #1;
    chk("q6", int'(q6), m6);
    chk("q8", int'(q8), m8);
    chk("err6", int'(err6), int'(e6));
    chk("err8", int'(err8), int'(e8));
`ifdef SYNCOUNT_UP_TC_REG_EN
    chk("tc6_reg", int'(tc6), int'(wr6));
    chk("tc8_reg", int'(tc8), int'(wr8));
    tc8_seen = int'(tc8);
`endif
    q6_seen = int'(q6);
    @(negedge clk);
  endtask

  initial begin
    int exp_seq[8];
    int pulses;
    exp_seq = '{1, 2, 3, 4, 5, 0, 1, 2};
    m6 = 0; m8 = 0; e6 = 0; e8 = 0; wr6 = 0; wr8 = 0;
    rst = 1; load = 0; val = 0; en = 0;
    @(negedge clk);

    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("reset_q6", q6_seen, 0);
    chk("reset_err6", int'(err6), 0);
    chk("reset_tc6", int'(tc6), 0);

    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 1);
      chk("seq6", q6_seen, exp_seq[i]);
    end

    cyc(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0);
      chk("hold6", q6_seen, 3);
      chk("hold_tc6", int'(tc6), 0);
    end
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("resume6", q6_seen, 5);

    cyc(0, 1, 2, 1);
    chk("load_pri6", q6_seen, 2);
    cyc(0, 0, 0, 1);
    chk("after_load6", q6_seen, 3);

    cyc(0, 1, 7, 0);
    chk("oor_q6", q6_seen, 0);
    chk("oor_err6", int'(err6), 1);
    cyc(0, 1, 4, 0);
    chk("reload_q6", q6_seen, 4);
    chk("sticky_err6", int'(err6), 1);

    cyc(1, 1, 1, 1);
    chk("rst_mid_q6", q6_seen, 0);
    chk("rst_mid_err6", int'(err6), 0);
    chk("rst_mid_tc6", int'(tc6), 0);

    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 1);
      pulses += tc8_seen;
    end
    chk("q8_after10", int'(q8), 2);
    chk("tc8_pulses", pulses, 1);

    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 29) == 0),
          ($urandom_range(0, 5) == 0),
          int'($urandom_range(0, 7)),
          ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/syncount_up.md
# syncount_up

Synchronous modulo-N up counter whose next-state logic is built from per-bit toggle enables driving T flip-flop cells, as the counting-up counterpart of the team's synchronous down counter. It counts 0 → MODULUS-1 and wraps to 0. It supports count enable, parallel load, a terminal-count indication for cascading, and a sticky load-range error flag. It sits in the Counters library beside the down counter and feeds timers and sequencers that need an ascending count.

## Interface
- `WIDTH`, default 3: counter width in bits, ≥ 1.
- `MODULUS`, default 8: count range 0..MODULUS-1; 2 ≤ MODULUS ≤ 2^WIDTH.
- `clk_i`, in, 1: single clock; all state updates on the rising edge.
- `rst_i`, in, 1: reset, synchronous and active-high.
- `en_i`, in, 1: count enable; advances the counter by 1 per cycle while high.
- `load_i`, in, 1: parallel load strobe.
- `load_val_i`, in, WIDTH: value captured on load.
- `q_o`, out, WIDTH: current count, registered.
- `tc_o`, out, 1: terminal count / wrap indication; timing depends on Configuration.
- `err_o`, out, 1: sticky flag for an out-of-range load.

## Operation
- Priority at each rising edge: `rst_i` > `load_i` > `en_i` > hold.
- **Reset:** `q_o` = 0, `err_o` = 0, `tc_o` = 0 (registered variant).
- **Load:** if `load_val_i` < MODULUS, then `q_o` ← `load_val_i`. Otherwise `q_o` ← 0 and `err_o` ← 1. Load overrides `en_i` in the same cycle; no increment is applied.
- **Count:** with `en_i`=1 and `load_i`=0, `q_o` ← `q_o`+1 when `q_o` < MODULUS-1, and `q_o` ← 0 when `q_o` == MODULUS-1.
- **Hold:** with `en_i`=0 and `load_i`=0, `q_o` is unchanged.
- **Next-state structure:**
  - Each bit k is a T flip-flop: q[k] ← q[k] ^ t[k].
  - Increment toggles: t[k] = &q[k-1:0] (t[0] = 1).
  - On wrap, t = q, which clears every set bit.
  - On load, t = q ^ load value.
  - On hold, t = 0.
- Arithmetic is unsigned, modulo MODULUS. No intermediate state outside 0..MODULUS-1 is ever visible on `q_o`.
- `err_o` stays 1 until `rst_i`. Later in-range loads do not clear it.
- When MODULUS = 2^WIDTH, the wrap compare reduces to natural overflow and the behaviour is identical.

## Timing
- **Latency:** `q_o` reflects a load or increment one cycle after the edge that samples `load_i` or `en_i`.
- **`tc_o`, combinational (default):** `tc_o` = (`q_o` == MODULUS-1) & `en_i` & ~`load_i` & ~`rst_i`. It is high in the same cycle as the edge that will wrap the counter, so it can drive `en_i` of a cascaded stage directly.
- **`tc_o`, registered variant:** `tc_o` is high for exactly one cycle after a wrap edge, coincident with `q_o` == 0.
- **Reset mid-count:** reset wins over any load or enable; the next cycle shows `q_o` = 0 and `tc_o` = 0.
- **Load while at MODULUS-1 with `en_i`=1:** no wrap occurs and `tc_o` is low, in both variants.
- **Continuous `en_i`:** the counter wraps every MODULUS cycles, with one `tc_o` pulse per wrap.

## Configuration
- Macro: `SYNCOUNT_UP_TC_REG_EN`.
- **Defined:** `tc_o` is a flip-flop. It is set on the wrap edge and cleared on the next edge unless another wrap occurs, which requires MODULUS = 1 and so cannot happen. Reset value is 0. There is no combinational path from `en_i` to `tc_o`.
- **Undefined:** `tc_o` is the combinational expression given in Timing.
- `q_o` and `err_o` behaviour is identical in both builds.

## Test plan
All scenarios use WIDTH=3, MODULUS=6 unless stated otherwise.

1. **Reset, then count:** assert `rst_i` for 2 cycles, then hold `en_i`=1 for 8 cycles → `q_o` sequence 0,1,2,3,4,5,0,1,2. `tc_o` is high in the cycle `q_o`=5 (combinational build) or the cycle `q_o`=0 after wrap (registered build).
2. **Enable gating:** count to 3, drop `en_i` for 4 cycles → `q_o` holds at 3, `tc_o`=0. Restore `en_i` → 4, 5, 0.
3. **Load priority:** at `q_o`=5 with `en_i`=1, assert `load_i` with `load_val_i`=2 → `q_o`=2, no `tc_o` pulse. The next enabled cycle gives 3.
4. **Out-of-range load:** `load_i` with `load_val_i`=7 → `q_o`=0, `err_o`=1. A later load of 4 gives `q_o`=4 with `err_o` still 1. Only `rst_i` clears `err_o`.
5. **Reset mid-operation:** at `q_o`=4, assert `rst_i`, `load_i` (value 1) and `en_i` together → `q_o`=0, `err_o`=0, `tc_o`=0.
6. **Power-of-two build:** WIDTH=3, MODULUS=8, `en_i`=1 for 10 cycles → `q_o` 0..7, 0, 1, with exactly one `tc_o` pulse.
